// File: rtl/alu_pkg.sv
// Shared opcode, state and classification definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MOD  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_DEC  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_XNOR = 4'hC;
  localparam logic [3:0] OP_NAND = 4'hD;
  localparam logic [3:0] OP_NOR  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic is_divmod(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result port bundle of the sequential ALU.
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid and its payload stay stable until that edge, ready may change freely.
interface alu_seq_if #(parameter int WIDTH = 8) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   y;
  logic                 zero;
  logic                 err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, err
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH
// accumulator (product / {remainder, quotient}) and one step counter.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [3:0]         mode_r;
  logic [CW-1:0]      cnt;
  logic               active;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] div_next;

  // Multiplier sits in the low half and shifts out as product bits shift in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Remainder needs one extra bit after the shift before the trial subtract.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, b_r};
  assign div_next = trial[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= OP_MUL;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= mode;
      acc    <= (mode == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      cnt    <= CW'(WIDTH - 1);
      active <= 1'b1;
    end else if (active) begin
      acc <= (mode_r == OP_MUL) ? mul_next : div_next;
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  assign done = active && (cnt == '0);

  always_comb begin
    result = '0;
    case (mode_r)
      OP_MUL:  result = acc;
      OP_DIV:  result = {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
      default: result = {{WIDTH{1'b0}}, acc[2*WIDTH-1:WIDTH]};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: FSM, operand capture, single-cycle datapath and
// registered result/flags; MUL/DIV/MOD are delegated to alu_iter_unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus,
  output state_t    dbg_state
);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] y_q;
  logic               zero_q;
  logic               err_q;

  logic               in_div0;
  logic               q_div0;
  logic               start;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_result;
  logic [WIDTH:0]     ext_a;
  logic [WIDTH:0]     ext_b;
  logic [2*WIDTH-1:0] single_y;
  logic [2*WIDTH-1:0] res_n;

  assign in_div0 = is_divmod(bus.op) && (bus.b == '0);
  assign q_div0  = is_divmod(op_q) && (b_q == '0);
  assign start   = (state == S_IDLE) && bus.in_valid && is_multi(bus.op) && !in_div0;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .done   (iter_done),
    .result (iter_result)
  );

  assign ext_a = {1'b0, a_q};
  assign ext_b = {1'b0, b_q};

  always_comb begin
    single_y = '0;
    case (op_q)
      OP_ADD:  single_y = {{(WIDTH-1){1'b0}}, ext_a + ext_b};
      OP_SUB:  single_y = {{(WIDTH-1){1'b0}}, ext_a - ext_b};
      OP_INC:  single_y = {{(WIDTH-1){1'b0}}, ext_a + 1'b1};
      OP_DEC:  single_y = {{(WIDTH-1){1'b0}}, ext_a - 1'b1};
      OP_SHR:  single_y = {{(WIDTH+1){1'b0}}, a_q[WIDTH-1:1]};
      OP_SHL:  single_y = {{(WIDTH-1){1'b0}}, a_q, 1'b0};
      OP_AND:  single_y = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   single_y = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR:  single_y = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_XNOR: single_y = {{WIDTH{1'b0}}, ~(a_q ^ b_q)};
      OP_NAND: single_y = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      OP_NOR:  single_y = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      OP_NOT:  single_y = {{WIDTH{1'b0}}, ~a_q};
      default: single_y = '0;
    endcase
  end

  // Divide-by-zero saturates the quotient and passes the dividend as remainder.
  always_comb begin
    res_n = single_y;
    if (q_div0)
      res_n = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_q};
    else if (is_multi(op_q))
      res_n = iter_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            state <= start ? S_BUSY : S_DONE;
          end
        end
        S_BUSY: begin
          if (iter_done) state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle registers the result; it then holds until taken.
          if (!out_valid_q) begin
            y_q         <= res_n;
            zero_q      <= (res_n == '0);
            err_q       <= q_div0;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance for the op table, reset abort
// and hold behaviour, and a 16-bit instance for back-to-back multiply.
module tb_alu_seq;
  import alu_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t st8;
  state_t st16;
  int     n_checks = 0;
  int     n_fail   = 0;

  alu_seq_if #(.WIDTH(8))  if8  ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave),  .dbg_state(st8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave), .dbg_state(st16));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one 8-bit transaction, check latency/result/flags, hold, then consume.
  task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] ey, input logic ee,
                      input int elat, input int hold);
    int   lat;
    int   t;
    logic rdy_seen;
    t = 0;
    while (!if8.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if8.in_valid = 1'b1;
    if8.a        = a;
    if8.b        = b;
    if8.op       = op;
    @(negedge clk);
    if8.in_valid = 1'b0;
    if8.a        = 8'($urandom_range(0, 255));
    if8.b        = 8'($urandom_range(0, 255));
    if8.op       = 4'($urandom_range(0, 15));
    lat      = 0;
    rdy_seen = 1'b0;
    while (!if8.out_valid && lat < 100) begin
      rdy_seen = rdy_seen | if8.in_ready;
      @(negedge clk);
      lat++;
    end
    rdy_seen = rdy_seen | if8.in_ready;
    check({tag, "_lat"},   64'(lat), 64'(elat));
    check({tag, "_rdy0"},  64'(rdy_seen), 64'd0);
    check({tag, "_y"},     64'(if8.y), 64'(ey));
    check({tag, "_zero"},  64'(if8.zero), 64'(ey == 16'h0000));
    check({tag, "_err"},   64'(if8.err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, 64'(if8.out_valid), 64'd1);
      check({tag, "_hold_y"}, 64'(if8.y), 64'(ey));
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(if8.out_valid), 64'd0);
    check({tag, "_rdy1"},    64'(if8.in_ready), 64'd1);
  endtask

  initial begin
    int acc1;
    int ov1;
    int acc2;
    int busy_rdy;
    int t;

    rst = 1'b1;
    if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.op = OP_ADD;  if8.out_ready = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.op = OP_ADD; if16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(st8), 64'(S_IDLE));
    check("rst_ov",    64'(if8.out_valid), 64'd0);
    check("rst_y",     64'(if8.y), 64'd0);
    check("rst_zero",  64'(if8.zero), 64'd0);
    check("rst_err",   64'(if8.err), 64'd0);
    check("rst_rdy",   64'(if8.in_ready), 64'd1);

    run8("add_ff",   OP_ADD,  8'hFF, 8'h01, 16'h0100, 1'b0, 1, 5);
    run8("mul_ff",   OP_MUL,  8'hFF, 8'hFF, 16'hFE01, 1'b0, 9, 0);
    run8("mul_small",OP_MUL,  8'h0C, 8'h0D, 16'h009C, 1'b0, 9, 0);
    run8("div",      OP_DIV,  8'd200, 8'd7, 16'd28,   1'b0, 9, 0);
    run8("mod",      OP_MOD,  8'd200, 8'd7, 16'd4,    1'b0, 9, 0);
    run8("div_lt",   OP_DIV,  8'd7, 8'd200, 16'd0,    1'b0, 9, 0);
    run8("mod_ff",   OP_MOD,  8'hFF, 8'h10, 16'h000F, 1'b0, 9, 0);
    run8("div0",     OP_DIV,  8'd200, 8'd0, 16'h00FF, 1'b1, 1, 0);
    run8("mod0",     OP_MOD,  8'h37, 8'h00, 16'h0037, 1'b1, 1, 0);
    run8("sub_brw",  OP_SUB,  8'd3, 8'd5,   16'h01FE, 1'b0, 1, 0);
    run8("sub",      OP_SUB,  8'd5, 8'd3,   16'h0002, 1'b0, 1, 0);
    run8("xor_z",    OP_XOR,  8'h5A, 8'h5A, 16'h0000, 1'b0, 1, 0);
    run8("inc",      OP_INC,  8'hFF, 8'h00, 16'h0100, 1'b0, 1, 0);
    run8("dec",      OP_DEC,  8'h00, 8'h00, 16'h01FF, 1'b0, 1, 0);
    run8("shl",      OP_SHL,  8'h81, 8'h00, 16'h0102, 1'b0, 1, 0);
    run8("shr",      OP_SHR,  8'h81, 8'h00, 16'h0040, 1'b0, 1, 0);
    run8("and",      OP_AND,  8'hF0, 8'h3C, 16'h0030, 1'b0, 1, 0);
    run8("or",       OP_OR,   8'h12, 8'h21, 16'h0033, 1'b0, 1, 0);
    run8("xnor",     OP_XNOR, 8'hA5, 8'h0F, 16'h0055, 1'b0, 1, 0);
    run8("nand",     OP_NAND, 8'hF0, 8'h3C, 16'h00CF, 1'b0, 1, 0);
    run8("nor",      OP_NOR,  8'h0F, 8'hF0, 16'h0000, 1'b0, 1, 0);
    run8("not",      OP_NOT,  8'h0F, 8'h00, 16'h00F0, 1'b0, 1, 0);

    // Reset during the 4th BUSY cycle of a multiply (y currently holds 0x00F0).
    if8.in_valid = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.op = OP_MUL;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy", 64'(st8), 64'(S_BUSY));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 64'(st8), 64'(S_IDLE));
    check("abort_ov",    64'(if8.out_valid), 64'd0);
    check("abort_y",     64'(if8.y), 64'd0);
    check("abort_rdy",   64'(if8.in_ready), 64'd1);
    run8("add_post", OP_ADD, 8'd2, 8'd3, 16'd5, 1'b0, 1, 0);

    // 16-bit back-to-back multiply with in_valid held and out_ready tied high.
    if16.a = 16'hFFFF; if16.b = 16'h0002; if16.op = OP_MUL; if16.in_valid = 1'b1;
    acc1 = -1; ov1 = -1; acc2 = -1; busy_rdy = 0;
    for (int i = 0; i < 80 && acc2 < 0; i++) begin
      if (if16.in_ready) begin
        if (acc1 < 0)      acc1 = i;
        else if (ov1 >= 0) acc2 = i;
        else               busy_rdy++;
      end
      if (if16.out_valid && ov1 < 0) begin
        ov1 = i;
        check("w16_y1",   64'(if16.y), 64'h0001FFFE);
        check("w16_err1", 64'(if16.err), 64'd0);
        check("w16_zero1",64'(if16.zero), 64'd0);
      end
      @(negedge clk);
    end
    if16.in_valid = 1'b0;
    check("w16_lat1",     64'(ov1 - acc1 - 1), 64'd17);
    check("w16_reaccept", 64'(acc2 - ov1), 64'd1);
    check("w16_busy_rdy", 64'(busy_rdy), 64'd0);
    t = 0;
    while (!if16.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("w16_lat2", 64'(t), 64'd17);
    check("w16_y2",   64'(if16.y), 64'h0001FFFE);
    @(negedge clk);
    check("w16_idle", 64'(st16), 64'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
